pwm_compare_4bit: RTL and testbench

Downstream consumer of the 4-bit up/down counter. It samples the counter's `count` and `up_down` every clock and produces a registered PWM waveform by comparing `count` against an active duty value. The block detects wrap-around period boundaries and load-induced jumps. New duty values arrive over a valid/ready handshake and are double-buffered so they only take effect at a period boundary.

---
 rtl/pwm_compare_4bit.sv | 51 +++++
 tb/tb_pwm_compare_4bit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pwm_compare_4bit.sv
// pwm_compare_4bit: registered PWM from sampled counter values, with wrap/jump detection
// and a double-buffered duty value that only takes effect on a period boundary.
module pwm_compare_4bit #(
  parameter logic [3:0] RESET_DUTY  = 4'd0,
  parameter bit         ACTIVE_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count,
  input  logic       up_down,
  input  logic [3:0] duty_data,
  input  logic       duty_valid,
  output logic       duty_ready,
  output logic       pwm_out,
  output logic       period_start,
  output logic       jump
);
  logic [3:0] prev_count, active_duty, pending_duty, next_duty;
  logic       prev_valid, pending, pending_next, boundary, step_ok, apply, xfer;
  always_comb begin
    step_ok      = count == (up_down ? prev_count + 4'd1 : prev_count - 4'd1);
    boundary     = prev_valid && (up_down ? (prev_count == 4'd15 && count == 4'd0)
                                          : (prev_count == 4'd0 && count == 4'd15));
    apply        = boundary && pending;
    next_duty    = apply ? pending_duty : active_duty;
    xfer         = duty_valid && duty_ready;
    // duty_ready mirrors !pending, so a transfer never coincides with an apply
    pending_next = xfer || (pending && !apply);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_valid   <= 1'b0;
      pending      <= 1'b0;
      active_duty  <= RESET_DUTY;
      pwm_out      <= !ACTIVE_HIGH;
      period_start <= 1'b0;
      jump         <= 1'b0;
      duty_ready   <= 1'b0;
    end else begin
      prev_count   <= count;
      prev_valid   <= 1'b1;
      active_duty  <= next_duty;
      pending      <= pending_next;
      duty_ready   <= !pending_next;
      if (xfer) pending_duty <= duty_data;
      pwm_out      <= (count < next_duty) ^ !ACTIVE_HIGH;
      period_start <= boundary;
      jump         <= prev_valid && !step_ok;
    end
  end
endmodule

// File: tb/tb_pwm_compare_4bit.sv
// tb_pwm_compare_4bit: table vectors plus scoreboarded sequences against a behavioural model;
// a second instance with inverted polarity is checked alongside.
module tb_pwm_compare_4bit;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] count = 4'd0;
  logic       up_down = 1'b1;
  logic [3:0] duty_data = 4'd0;
  logic       duty_valid = 1'b0;
  logic       duty_ready, pwm_out, period_start, jump;
  logic       duty_ready_n, pwm_out_n, period_start_n, jump_n;

  pwm_compare_4bit dut (
    .clk(clk), .reset(reset), .count(count), .up_down(up_down),
    .duty_data(duty_data), .duty_valid(duty_valid), .duty_ready(duty_ready),
    .pwm_out(pwm_out), .period_start(period_start), .jump(jump)
  );

  pwm_compare_4bit #(.RESET_DUTY(4'd0), .ACTIVE_HIGH(1'b0)) dut_n (
    .clk(clk), .reset(reset), .count(count), .up_down(up_down),
    .duty_data(duty_data), .duty_valid(duty_valid), .duty_ready(duty_ready_n),
    .pwm_out(pwm_out_n), .period_start(period_start_n), .jump(jump_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] cnt;
    logic       ud;
    logic [3:0] dd;
    logic       dv;
    logic       pwm;
    logic       ps;
    logic       j;
    logic       rdy;
  } vec_t;

  typedef struct {
    logic pwm;
    logic ps;
    logic j;
    logic rdy;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [3:0] cur = 4'd0;

  int m_prev = 0, m_act = 0, m_pdut = 0;
  bit m_pv = 0, m_pend = 0, m_rdy = 0;

  task automatic chk(input string name, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] c, input logic ud,
                      input logic [3:0] dd, input logic dv);
    exp_t e;
    bit bnd, jmp, xf;
    @(negedge clk);
    reset = r; count = c; up_down = ud; duty_data = dd; duty_valid = dv;
    if (r) begin
      m_pv = 0; m_pend = 0; m_act = 0; m_rdy = 0;
      e = '{1'b0, 1'b0, 1'b0, 1'b0};
    end else begin
      bnd = 0; jmp = 0;
      if (m_pv) begin
        if (ud ? (m_prev == 15 && c == 0) : (m_prev == 0 && c == 15)) bnd = 1;
        else if (int'(c) != (ud ? (m_prev + 1) % 16 : (m_prev + 15) % 16)) jmp = 1;
      end
      xf = dv && m_rdy;
      if (bnd && m_pend) begin m_act = m_pdut; m_pend = 0; end
      if (xf) begin m_pdut = int'(dd); m_pend = 1; end
      m_rdy = !m_pend; m_pv = 1; m_prev = int'(c);
      e = '{int'(c) < m_act, bnd, jmp, !m_pend};
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk("pwm_out", pwm_out, e.pwm);
    chk("pwm_out_inv", pwm_out_n, !e.pwm);
    chk("period_start", period_start, e.ps);
    chk("jump", jump, e.j);
    chk("duty_ready", duty_ready, e.rdy);
  endtask

  task automatic run(input int n, input logic ud);
    for (int i = 0; i < n; i++) begin
      cur = ud ? cur + 4'd1 : cur - 4'd1;
      step(1'b0, cur, ud, 4'd0, 1'b0);
    end
  endtask

  // holds duty_valid high while counting until the model accepts the value
  task automatic offer(input logic [3:0] d, input logic ud);
    bit acc;
    int k;
    acc = 0;
    for (k = 0; k < 40 && !acc; k++) begin
      acc = m_rdy;
      cur = ud ? cur + 4'd1 : cur - 4'd1;
      step(1'b0, cur, ud, d, 1'b1);
    end
    if (!acc) chk("offer_timeout", 1'b0, 1'b1);
  endtask

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 5, 1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 10, 1, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 3, 1, 0, 0, 0, 0, 0, 1};
    tbl[4]  = '{0, 4, 1, 7, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 10, 1, 0, 0, 0, 0, 1, 0};
    tbl[6]  = '{0, 11, 1, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 12, 1, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 13, 1, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 14, 1, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 15, 1, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 1, 0, 0, 1, 1, 0, 1};
    tbl[12] = '{0, 1, 1, 0, 0, 1, 0, 0, 1};
    tbl[13] = '{0, 1, 1, 0, 0, 1, 0, 1, 1};
    tbl[14] = '{0, 7, 1, 0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].cnt, tbl[i].ud, tbl[i].dd, tbl[i].dv);
      chk("tbl_pwm", pwm_out, tbl[i].pwm);
      chk("tbl_period_start", period_start, tbl[i].ps);
      chk("tbl_jump", jump, tbl[i].j);
      chk("tbl_duty_ready", duty_ready, tbl[i].rdy);
    end
    cur = 4'd7;
    offer(4'd5, 1'b1);
    run(48, 1'b1);
    offer(4'd8, 1'b0);
    run(48, 1'b0);
    offer(4'd3, 1'b1);
    run(20, 1'b1);
    for (int i = 0; i < 16 && cur != 4'd5; i++) run(1, 1'b1);
    offer(4'd12, 1'b1);
    chk("pend_ready_low", duty_ready, 1'b0);
    offer(4'd9, 1'b1);
    run(40, 1'b1);
    offer(4'd0, 1'b1);
    run(36, 1'b1);
    offer(4'd15, 1'b1);
    run(36, 1'b1);
    offer(4'd6, 1'b1);
    step(1'b1, cur, 1'b1, 4'd0, 1'b0);
    step(1'b1, cur, 1'b1, 4'd0, 1'b0);
    run(20, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule
